// File: rtl/register_file_param.sv
// register_file_param: parametrised 3-read / 1-write register file.
// After reset the whole array is cleared one entry per cycle; ready
// rises once every entry has been zeroed.
// PC_REG mirrors program_counter while it is below PC_LIMIT.
// IO_REG mirrors io_data on every RUN cycle.
// write_conflict flags general writes that target either of these
// hardware-owned entries.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a
// same-cycle write is forwarded combinationally to any read port that
// addresses it.
module register_file_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int PC_WIDTH   = 12,
    parameter int PC_REG     = 28,
    parameter int IO_REG     = 29,
    parameter int PC_LIMIT   = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_address_a,
    input  logic [ADDR_WIDTH-1:0] read_address_b,
    input  logic [ADDR_WIDTH-1:0] read_address_c,
    input  logic [PC_WIDTH-1:0]   program_counter,
    input  logic [DATA_WIDTH-1:0] io_data,
    output logic [DATA_WIDTH-1:0] dataA,
    output logic [DATA_WIDTH-1:0] dataB,
    output logic [DATA_WIDTH-1:0] dataC,
    output logic                  ready,
    output logic                  write_conflict
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_IDX   = ADDR_WIDTH'(PC_REG);
    localparam logic [ADDR_WIDTH-1:0] IO_IDX   = ADDR_WIDTH'(IO_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {CLEAR, RUN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clear_index;
    logic [DATA_WIDTH-1:0]   rf [DEPTH];

    logic                    pc_in_range;
    logic [DATA_WIDTH-1:0]   pc_ext;
    logic                    hits_hw_reg;

    // Unsigned compare: both sides are widened to 32 bits, so a
    // PC_LIMIT above 2**PC_WIDTH simply means "always in range".
    assign pc_in_range = 32'(program_counter) < 32'(PC_LIMIT);
    assign pc_ext      = DATA_WIDTH'(program_counter);
    assign hits_hw_reg = (write_address == PC_IDX) || (write_address == IO_IDX);

    // Clear sequencer and run-time update.
    // Later assignments win for the same entry, which gives the
    // priority io mirror > pc mirror > general write.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= CLEAR;
            clear_index    <= '0;
            ready          <= 1'b0;
            write_conflict <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    rf[clear_index] <= '0;
                    write_conflict  <= 1'b0;
                    // The index parks on the last entry rather than wrapping.
                    if (clear_index == LAST_IDX) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        clear_index <= clear_index + 1'b1;
                    end
                end
                RUN: begin
                    if (write_enable)
                        rf[write_address] <= write_data;
                    if (pc_in_range)
                        rf[PC_IDX] <= pc_ext;
                    rf[IO_IDX]     <= io_data;
                    write_conflict <= write_enable && hits_hw_reg;
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

    logic [2:0][ADDR_WIDTH-1:0] raddr;
    logic [2:0][DATA_WIDTH-1:0] rdata;

    assign raddr = {read_address_c, read_address_b, read_address_a};

    // Asynchronous read ports. Each port reads 0 until the clear is done.
    always_comb begin
        rdata = '0;
        for (int p = 0; p < 3; p++) begin
            if (ready) begin
                rdata[p] = rf[raddr[p]];
`ifdef REGFILE_BYPASS_EN
                // Skip forwarding into hardware-owned entries: the
                // general write to them loses (or may lose) anyway.
                if (write_enable && (raddr[p] == write_address) && !hits_hw_reg)
                    rdata[p] = write_data;
`endif
            end
        end
    end

    assign dataA = rdata[0];
    assign dataB = rdata[1];
    assign dataC = rdata[2];

endmodule

// File: tb/tb_register_file_param.sv
// Self-checking bench for register_file_param. A behavioural model of
// the register file is checked against the DUT on every falling edge.
// Directed literal checks pin the model to the expected numbers.
module tb_register_file_param;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int PW    = 12;
    localparam int DEPTH = 32;
    localparam int PCR   = 28;
    localparam int IOR   = 29;
    localparam int PCLIM = 256;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          write_enable = 1'b0;
    logic [AW-1:0] write_address = '0;
    logic [DW-1:0] write_data = '0;
    logic [AW-1:0] read_address_a = '0;
    logic [AW-1:0] read_address_b = '0;
    logic [AW-1:0] read_address_c = '0;
    logic [PW-1:0] program_counter = 12'h300;
    logic [DW-1:0] io_data = '0;
    logic [DW-1:0] dataA, dataB, dataC;
    logic          ready, write_conflict;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    register_file_param dut (
        .clock(clock), .reset(reset),
        .write_enable(write_enable), .write_address(write_address),
        .write_data(write_data),
        .read_address_a(read_address_a), .read_address_b(read_address_b),
        .read_address_c(read_address_c),
        .program_counter(program_counter), .io_data(io_data),
        .dataA(dataA), .dataB(dataB), .dataC(dataC),
        .ready(ready), .write_conflict(write_conflict)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_rf [DEPTH];
    int            m_cycles = 0;   // cycles since reset released
    bit            m_ready  = 1'b0;
    bit            m_conf   = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_cycles = 0;
            m_ready  = 1'b0;
            m_conf   = 1'b0;
        end else if (!m_ready) begin
            m_cycles++;
            m_conf = 1'b0;
            if (m_cycles == DEPTH) begin
                m_ready = 1'b1;
                for (int i = 0; i < DEPTH; i++) m_rf[i] = '0;
            end
        end else begin
            if (write_enable) m_rf[write_address] = write_data;
            if (int'(program_counter) < PCLIM) m_rf[PCR] = DW'(program_counter);
            m_rf[IOR] = io_data;
            m_conf = write_enable && (int'(write_address) == PCR || int'(write_address) == IOR);
        end
    end

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (!m_ready) return '0;
`ifdef REGFILE_BYPASS_EN
        if (write_enable && a == write_address &&
            int'(a) != PCR && int'(a) != IOR) return write_data;
`endif
        return m_rf[a];
    endfunction

    task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge once the first reset was seen.
    always @(negedge clock) begin
        if (started) begin
            cmp("dataA", dataA, exp_rd(read_address_a));
            cmp("dataB", dataB, exp_rd(read_address_b));
            cmp("dataC", dataC, exp_rd(read_address_c));
            cmp("ready", DW'(ready), DW'(m_ready));
            cmp("write_conflict", DW'(write_conflict), DW'(m_conf));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reset, then issue a write to r3 throughout the clear; ready must
    // rise exactly on the 32nd edge after release and r3 must read 0.
    task automatic clear_check(input string tag);
        write_enable  = 1'b1;
        write_address = 5'd3;
        write_data    = 32'h55;
        for (int i = 1; i < DEPTH; i++) begin
            step();
            if (i == 1 || i == DEPTH - 1) begin
                cmp({tag, "_ready_low"}, DW'(ready), 32'd0);
                cmp({tag, "_dataA_zero"}, dataA, 32'd0);
            end
        end
        step();
        cmp({tag, "_ready_32nd"}, DW'(ready), 32'd1);
        write_enable   = 1'b0;
        read_address_b = 5'd3;
        #1;
        cmp({tag, "_r3_dropped"}, dataB, 32'd0);
    endtask

    initial begin
        // Initial reset, one cycle.
        step();
        started = 1'b1;
        reset   = 1'b0;
        clear_check("clr1");

        // Every address reads 0 after the clear (PC/IO entries not yet updated).
        for (int a = 0; a < DEPTH; a++) begin
            read_address_c = AW'(a);
            #1;
            if (a != PCR && a != IOR) cmp("all_zero", dataC, 32'd0);
        end

        // Write r5; not visible before the edge unless bypass is enabled.
        write_enable = 1'b1; write_address = 5'd5; write_data = 32'hDEADBEEF;
        read_address_b = 5'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        cmp("r5_same_cycle", dataB, 32'hDEADBEEF);
`else
        cmp("r5_same_cycle", dataB, 32'd0);
`endif
        step();
        write_enable = 1'b0;
        cmp("r5_next_cycle", dataB, 32'hDEADBEEF);

        // PC mirror, limit, IO mirror.
        program_counter = 12'h0FF; read_address_a = 5'd28;
        step();
        cmp("pc_0ff", dataA, 32'h000000FF);
        program_counter = 12'h100;
        step();
        cmp("pc_limit_hold", dataA, 32'h000000FF);
        io_data = 32'h12345678; read_address_a = 5'd29;
        step();
        cmp("io_mirror", dataA, 32'h12345678);

        // General write to IO_REG always loses; conflict for one cycle.
        write_enable = 1'b1; write_address = 5'd29; write_data = 32'hAAAA;
        io_data = 32'h5555;
        step();
        write_enable = 1'b0;
        cmp("io_wins", dataA, 32'h5555);
        cmp("conflict_io", DW'(write_conflict), 32'd1);
        step();
        cmp("conflict_clears", DW'(write_conflict), 32'd0);

        // General write to PC_REG survives only when the PC is out of range.
        program_counter = 12'h300; read_address_a = 5'd28;
        write_enable = 1'b1; write_address = 5'd28; write_data = 32'h7;
        step();
        write_enable = 1'b0;
        cmp("pc_write_survives", dataA, 32'h7);
        cmp("conflict_pc", DW'(write_conflict), 32'd1);
        program_counter = 12'h010;
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
        program_counter = 12'h300;
        cmp("pc_write_lost", dataA, 32'h10);
        cmp("conflict_pc2", DW'(write_conflict), 32'd1);

        // Reset mid-clear restarts the full clear.
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_check("clr2");

        // Randomised run, with occasional resets; the compare process checks it.
        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 599) == 0);
            write_enable   = $urandom_range(0, 2) != 0;
            write_address  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(28, 29))
                                                         : AW'($urandom);
            write_data     = $urandom;
            read_address_a = ($urandom_range(0, 3) == 0) ? write_address : AW'($urandom);
            read_address_b = ($urandom_range(0, 3) == 0) ? write_address : AW'($urandom);
            read_address_c = AW'($urandom);
            program_counter = ($urandom_range(0, 1) == 0) ? PW'($urandom_range(0, 255))
                                                          : PW'($urandom);
            io_data        = $urandom;
            step();
        end
        reset = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
